// File: rtl/clock_enable_gen.sv
// ---------------------------------------------------------------------------
// clock_enable_gen
//
// Multi-channel clock-enable divider for the 104 MHz domain. Each channel
// counts "advance" events and emits a one-cycle tick every N events, plus a
// 50%-duty clk_out that toggles on every tick. A channel advances on every
// clock cycle, or, when its cascade bit is set, on the registered tick of the
// channel below it. This lets channels be chained to reach long periods.
//
// New divisors are posted through a single-entry pending register per
// channel. A posted divisor takes effect at the channel's next wrap, or on
// the next edge if the channel is halted (divisor 0). div_ack pulses for one
// cycle after the new divisor has taken effect.
//
// Parameters
//   NUM_CH     number of channels (1..8)
//   CNT_W      counter / divisor width
//   SEL_W      width of div_sel (>= clog2(NUM_CH))
//   DIV_INIT   packed reset divisors, channel i in [i*CNT_W +: CNT_W]
//   CASC_INIT  reset value of the cascade mask (bit 0 ignored)
//
// Ports
//   clock_104mhz  in   system clock
//   reset_n       in   asynchronous active-low reset
//   sync_clear    in   synchronous clear of all channels (SYNC_CLEAR_EN only)
//   div_wr        in   divisor write strobe
//   div_sel       in   channel targeted by the write
//   div_val       in   new divisor (0 halts the channel)
//   div_ready     out  selected channel has no pending update
//   div_ack       out  per-channel pulse: pending divisor was applied
//   casc_wr       in   load cascade mask from casc_val
//   casc_val      in   cascade mask, bit i: channel i counts tick[i-1]
//   tick          out  per-channel one-cycle enable
//   clk_out       out  per-channel toggle output (period 2N)
//
// Configuration macro
//   SYNC_CLEAR_EN  adds the sync_clear input. sync_clear zeroes every
//                  counter and output and applies all pending divisors at
//                  once.
// ---------------------------------------------------------------------------
module clock_enable_gen #(
    parameter int                         NUM_CH    = 2,
    parameter int                         CNT_W     = 16,
    parameter int                         SEL_W     = 1,
    parameter logic [NUM_CH*CNT_W-1:0]    DIV_INIT  = {16'd128, 16'd52},
    parameter logic [NUM_CH-1:0]          CASC_INIT = 2'b10
) (
    input  logic              clock_104mhz,
    input  logic              reset_n,
`ifdef SYNC_CLEAR_EN
    input  logic              sync_clear,
`endif
    input  logic              div_wr,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [CNT_W-1:0]  div_val,
    output logic              div_ready,
    output logic [NUM_CH-1:0] div_ack,
    input  logic              casc_wr,
    input  logic [NUM_CH-1:0] casc_val,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);

    // Channel 0 has no source below it, so its cascade bit is held at 0.
    localparam logic [NUM_CH-1:0] CASC_MASK = ~(NUM_CH)'(1);

    logic [NUM_CH-1:0] r_casc;
    logic [NUM_CH-1:0] w_sel_hit;
    logic [NUM_CH-1:0] w_pending;

    always_ff @(posedge clock_104mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_casc <= CASC_INIT & CASC_MASK;
        end else if (casc_wr) begin
            r_casc <= casc_val & CASC_MASK;
        end
    end

    // An out-of-range div_sel matches no channel. div_ready is then 0,
    // so the write is dropped.
    assign div_ready = |(w_sel_hit & ~w_pending);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] r_div;
        logic [CNT_W-1:0] r_pend;
        logic             r_pending;
        logic [CNT_W-1:0] r_cnt;
        logic             r_tick;
        logic             r_clk;
        logic             r_ack;

        logic             w_src;
        logic             w_adv;
        logic             w_halted;
        logic             w_term;
        logic             w_wr_hit;
        logic             w_apply;

        if (i == 0) begin : g_src0
            assign w_src = 1'b0;
        end else begin : g_srcn
            assign w_src = tick[i-1];
        end

        assign w_sel_hit[i] = (div_sel == SEL_W'(i));
        assign w_wr_hit     = div_wr & div_ready & w_sel_hit[i];
        assign w_adv        = r_casc[i] ? w_src : 1'b1;
        assign w_halted     = (r_div == '0);
        // Full-width terminal compare, so N = 2^CNT_W-1 works.
        assign w_term       = (r_cnt == (r_div - CNT_W'(1)));
        // A halted channel picks up its new divisor on the very next edge.
        // A running channel waits for its wrap, so the period in flight is
        // never cut short.
        assign w_apply      = r_pending & (w_halted | (w_adv & w_term));

        always_ff @(posedge clock_104mhz or negedge reset_n) begin
            if (!reset_n) begin
                r_div     <= DIV_INIT[i*CNT_W +: CNT_W];
                r_pend    <= '0;
                r_pending <= 1'b0;
                r_cnt     <= '0;
                r_tick    <= 1'b0;
                r_clk     <= 1'b0;
                r_ack     <= 1'b0;
            end else begin
                r_ack <= 1'b0;
                // A write only hits a channel with nothing pending. It
                // therefore never collides with an apply on this channel.
                if (w_wr_hit) begin
                    r_pend    <= div_val;
                    r_pending <= 1'b1;
                end
`ifdef SYNC_CLEAR_EN
                if (sync_clear) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b0;
                    r_clk  <= 1'b0;
                    if (r_pending) begin
                        r_div     <= r_pend;
                        r_pending <= 1'b0;
                        r_ack     <= 1'b1;
                    end
                end else
`endif
                begin
                    if (w_halted) begin
                        r_cnt  <= '0;
                        r_tick <= 1'b0;
                    end else if (w_adv) begin
                        if (w_term) begin
                            r_cnt  <= '0;
                            r_tick <= 1'b1;
                            r_clk  <= ~r_clk;
                        end else begin
                            r_cnt  <= r_cnt + CNT_W'(1);
                            r_tick <= 1'b0;
                        end
                    end else begin
                        r_tick <= 1'b0;
                    end
                    // The wrap tick above is still emitted. The apply only
                    // swaps the divisor and restarts the count.
                    if (w_apply) begin
                        r_div     <= r_pend;
                        r_cnt     <= '0;
                        r_pending <= 1'b0;
                        r_ack     <= 1'b1;
                    end
                end
            end
        end

        assign w_pending[i] = r_pending;
        assign tick[i]      = r_tick;
        assign clk_out[i]   = r_clk;
        assign div_ack[i]   = r_ack;
    end

endmodule

// File: tb/tb_clock_enable_gen.sv
module tb_clock_enable_gen;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 16;
    localparam int SEL_W  = 1;

    logic              clock_104mhz = 1'b0;
    logic              reset_n      = 1'b0;
    logic              div_wr       = 1'b0;
    logic [SEL_W-1:0]  div_sel      = '0;
    logic [CNT_W-1:0]  div_val      = '0;
    logic              div_ready;
    logic [NUM_CH-1:0] div_ack;
    logic              casc_wr      = 1'b0;
    logic [NUM_CH-1:0] casc_val     = '0;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_out;
`ifdef SYNC_CLEAR_EN
    logic              sync_clear   = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clock_104mhz = ~clock_104mhz;

    // ch0 = 4, ch1 = 3, no cascade at reset
    clock_enable_gen #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .SEL_W    (SEL_W),
        .DIV_INIT ({16'd3, 16'd4}),
        .CASC_INIT(2'b00)
    ) dut (
        .clock_104mhz(clock_104mhz),
        .reset_n     (reset_n),
`ifdef SYNC_CLEAR_EN
        .sync_clear  (sync_clear),
`endif
        .div_wr      (div_wr),
        .div_sel     (div_sel),
        .div_val     (div_val),
        .div_ready   (div_ready),
        .div_ack     (div_ack),
        .casc_wr     (casc_wr),
        .casc_val    (casc_val),
        .tick        (tick),
        .clk_out     (clk_out)
    );

    task automatic step();
        @(posedge clock_104mhz);
        #1;
    endtask

    // Leaves reset released just after an edge; the next edge is cycle 1.
    task automatic do_reset();
        reset_n  = 1'b0;
        div_wr   = 1'b0;
        casc_wr  = 1'b0;
        div_sel  = '0;
`ifdef SYNC_CLEAR_EN
        sync_clear = 1'b0;
`endif
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        step();
        step();
        n_vec++;
        if (tick !== 2'b00) begin n_err++; $display("FAIL reset_tick got %b want 00", tick); end
        n_vec++;
        if (clk_out !== 2'b00) begin n_err++; $display("FAIL reset_clk got %b want 00", clk_out); end
        n_vec++;
        if (div_ack !== 2'b00) begin n_err++; $display("FAIL reset_ack got %b want 00", div_ack); end
        n_vec++;
        if (div_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", div_ready); end
    endtask

    task automatic test_free_run();
        logic [1:0] et, ec;
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            step();
            et[0] = (k % 4 == 0);
            et[1] = (k % 3 == 0);
            ec[0] = ((k / 4) % 2) == 1;
            ec[1] = ((k / 3) % 2) == 1;
            n_vec++;
            if (tick !== et) begin n_err++; $display("FAIL free_tick k=%0d got %b want %b", k, tick, et); end
            n_vec++;
            if (clk_out !== ec) begin n_err++; $display("FAIL free_clk k=%0d got %b want %b", k, clk_out, ec); end
        end
    endtask

    task automatic test_n1();
        do_reset();
        div_wr = 1'b1; div_sel = 1'b0; div_val = 16'd1;
        step();
        div_wr = 1'b0;
        step();
        step();
        step();
        // cycle 4: wrap with apply
        n_vec++;
        if (tick[0] !== 1'b1 || clk_out[0] !== 1'b1 || div_ack !== 2'b01) begin
            n_err++;
            $display("FAIL n1_apply got tick=%b clk=%b ack=%b want 1 1 01", tick[0], clk_out[0], div_ack);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            n_vec++;
            if (tick[0] !== 1'b1 || clk_out[0] !== (k % 2 == 0) || div_ack[0] !== 1'b0) begin
                n_err++;
                $display("FAIL n1_run k=%0d got tick=%b clk=%b ack=%b want 1 %b 0",
                         k, tick[0], clk_out[0], div_ack[0], (k % 2 == 0));
            end
        end
    endtask

    task automatic test_pending();
        do_reset();
        step();
        n_vec++;
        if (div_ready !== 1'b1) begin n_err++; $display("FAIL pend_ready0 got %b want 1", div_ready); end
        div_wr = 1'b1; div_sel = 1'b0; div_val = 16'd6;
        step();
        div_val = 16'd9;
        n_vec++;
        if (div_ready !== 1'b0) begin n_err++; $display("FAIL pend_busy got %b want 0", div_ready); end
        step();
        div_wr = 1'b0;
        n_vec++;
        if (tick[0] !== 1'b0 || div_ack !== 2'b00) begin
            n_err++; $display("FAIL pend_wait got tick=%b ack=%b want 0 00", tick[0], div_ack);
        end
        step();
        n_vec++;
        if (tick[0] !== 1'b1 || div_ack !== 2'b01 || div_ready !== 1'b1) begin
            n_err++;
            $display("FAIL pend_apply got tick=%b ack=%b rdy=%b want 1 01 1", tick[0], div_ack, div_ready);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            n_vec++;
            if (tick[0] !== (k % 6 == 0) || div_ack[0] !== 1'b0) begin
                n_err++;
                $display("FAIL pend_period k=%0d got tick=%b ack=%b want %b 0", k, tick[0], div_ack[0], (k % 6 == 0));
            end
        end
    endtask

    task automatic test_halt();
        do_reset();
        div_wr = 1'b1; div_sel = 1'b1; div_val = 16'd0;
        step();
        div_wr = 1'b0;
        step();
        step();
        n_vec++;
        if (tick[1] !== 1'b1 || clk_out[1] !== 1'b1 || div_ack !== 2'b10) begin
            n_err++;
            $display("FAIL halt_apply got tick=%b clk=%b ack=%b want 1 1 10", tick[1], clk_out[1], div_ack);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            n_vec++;
            if (tick[1] !== 1'b0 || clk_out[1] !== 1'b1) begin
                n_err++; $display("FAIL halt_hold k=%0d got tick=%b clk=%b want 0 1", k, tick[1], clk_out[1]);
            end
        end
        div_wr = 1'b1; div_sel = 1'b1; div_val = 16'd5;
        step();
        div_wr = 1'b0;
        step();
        n_vec++;
        if (div_ack !== 2'b10 || tick[1] !== 1'b0) begin
            n_err++; $display("FAIL halt_restart got ack=%b tick=%b want 10 0", div_ack, tick[1]);
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            n_vec++;
            if (tick[1] !== (k == 5) || clk_out[1] !== (k != 5)) begin
                n_err++;
                $display("FAIL halt_first k=%0d got tick=%b clk=%b want %b %b", k, tick[1], clk_out[1], (k == 5), (k != 5));
            end
        end
    endtask

    task automatic test_cascade();
        logic p0;
        bit   found;
        int   cyc, n0;
        do_reset();
        div_wr = 1'b1; div_sel = 1'b0; div_val = 16'd52;
        step();
        div_sel = 1'b1; div_val = 16'd128;
        step();
        div_wr = 1'b0; casc_wr = 1'b1; casc_val = 2'b10;
        step();
        casc_wr = 1'b0;
        found = 1'b0;
        p0 = tick[0];
        for (int c = 0; c < 8000 && !found; c++) begin
            step();
            if (tick[1]) found = 1'b1;
            else p0 = tick[0];
        end
        n_vec++;
        if (!found) begin n_err++; $display("FAIL casc_first got no tick1 want tick1 within 8000"); end
        n_vec++;
        if (p0 !== 1'b1) begin n_err++; $display("FAIL casc_lag1 got tick0_prev=%b want 1", p0); end
        found = 1'b0;
        cyc = 0;
        n0 = 0;
        p0 = tick[0];
        for (int c = 0; c < 8000 && !found; c++) begin
            step();
            cyc++;
            if (tick[1]) found = 1'b1;
            else begin
                p0 = tick[0];
                if (tick[0]) n0++;
            end
        end
        n_vec++;
        if (cyc != 6656) begin n_err++; $display("FAIL casc_period got %0d want 6656", cyc); end
        n_vec++;
        if (n0 != 128) begin n_err++; $display("FAIL casc_src_ticks got %0d want 128", n0); end
        n_vec++;
        if (p0 !== 1'b1) begin n_err++; $display("FAIL casc_lag2 got tick0_prev=%b want 1", p0); end
    endtask

    task automatic test_async_reset();
        logic [1:0] et;
        do_reset();
        step();
        step();
        step();
        div_wr = 1'b1; div_sel = 1'b1; div_val = 16'd7;
        step();
        div_wr = 1'b0;
        n_vec++;
        if (tick !== 2'b01 || clk_out !== 2'b11 || div_ready !== 1'b0) begin
            n_err++;
            $display("FAIL arst_pre got tick=%b clk=%b rdy=%b want 01 11 0", tick, clk_out, div_ready);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (tick !== 2'b00 || clk_out !== 2'b00 || div_ack !== 2'b00 || div_ready !== 1'b1) begin
            n_err++;
            $display("FAIL arst_now got tick=%b clk=%b ack=%b rdy=%b want 00 00 00 1", tick, clk_out, div_ack, div_ready);
        end
        step();
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            et[0] = (k % 4 == 0);
            et[1] = (k % 3 == 0);
            n_vec++;
            if (tick !== et) begin n_err++; $display("FAIL arst_resume k=%0d got %b want %b", k, tick, et); end
        end
    endtask

`ifdef SYNC_CLEAR_EN
    task automatic test_sync_clear();
        logic [1:0] et;
        do_reset();
        step();
        step();
        div_wr = 1'b1; div_sel = 1'b0; div_val = 16'd5;
        step();
        div_wr = 1'b0;
        sync_clear = 1'b1;
        step();
        sync_clear = 1'b0;
        n_vec++;
        if (tick !== 2'b00 || clk_out !== 2'b00 || div_ack !== 2'b01) begin
            n_err++;
            $display("FAIL sclr_now got tick=%b clk=%b ack=%b want 00 00 01", tick, clk_out, div_ack);
        end
        for (int k = 1; k <= 10; k++) begin
            step();
            et[0] = (k % 5 == 0);
            et[1] = (k % 3 == 0);
            n_vec++;
            if (tick !== et) begin n_err++; $display("FAIL sclr_align k=%0d got %b want %b", k, tick, et); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_free_run();
        test_n1();
        test_pending();
        test_halt();
        test_cascade();
        test_async_reset();
`ifdef SYNC_CLEAR_EN
        test_sync_clear();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
